// File: rtl/fabric_fifo_if.sv
// Stream handshake bundle for fabric_fifo: upstream (in_*) and downstream (out_*) sides.
// The producer/consumer environment uses master; the FIFO uses slave.
interface fabric_fifo_if #(
  parameter int PAYLOAD_WIDTH = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [PAYLOAD_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAYLOAD_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fabric_fifo.sv
// Elastic circular-buffer stage for one fabric stream channel, with optional
// combinational bypass and a sticky first-error latch.
module fabric_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 0,
  parameter int BYPASSABLE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fabric_fifo_if.slave  link,
  input  logic          cfg_bypass,
  output logic          error_valid,
  output logic [15:0]   error_code
);

  localparam int PW    = DATA_WIDTH + TAG_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [15:0]      CFG_FIFO_BYPASS_UNSUPPORTED = 16'd3;
  localparam logic [15:0]      RT_FIFO_BYPASS_NONEMPTY     = 16'd263;

  if ((DEPTH < 1) || (DEPTH > 256)) begin : g_depth_check
    $fatal(1, "COMP_FIFO_DEPTH");
  end

  logic [PW-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             err_valid_r;
  logic [15:0]      err_code_r;

  logic             bypass_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic [PW-1:0]    out_data_s;
  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             err_det_s;
  logic [15:0]      err_code_s;

  // Mode select and handshake outputs; bypass only exists when the parameter allows it.
  always_comb begin
    bypass_s    = 1'b0;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = mem_r[rd_ptr_r];
    if (BYPASSABLE != 0) begin
      bypass_s = cfg_bypass;
    end else begin
      bypass_s = 1'b0;
    end
    if (bypass_s) begin
      in_ready_s  = link.out_ready;
      out_valid_s = link.in_valid;
      out_data_s  = link.in_data;
    end else begin
      // in_ready is purely occupancy based so no ready path crosses the stage
      in_ready_s  = (count_r != FULL_CNT);
      out_valid_s = (count_r != ZERO_CNT);
      out_data_s  = mem_r[rd_ptr_r];
    end
    push_s = ~bypass_s & link.in_valid & in_ready_s;
    pop_s  = ~bypass_s & out_valid_s & link.out_ready;
  end

  // Next pointer/count values; wrap by explicit compare so any DEPTH works.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    if (push_s) begin
      wr_ptr_nxt_s = (wr_ptr_r == LAST_PTR) ? ZERO_PTR : (wr_ptr_r + PTR_W'(1));
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = (rd_ptr_r == LAST_PTR) ? ZERO_PTR : (rd_ptr_r + PTR_W'(1));
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Error detection; the two conditions are exclusive, code 3 checked first.
  always_comb begin
    err_det_s  = 1'b0;
    err_code_s = 16'd0;
    if (cfg_bypass && (BYPASSABLE == 0)) begin
      err_det_s  = 1'b1;
      err_code_s = CFG_FIFO_BYPASS_UNSUPPORTED;
    end else if (cfg_bypass && (count_r != ZERO_CNT)) begin
      err_det_s  = 1'b1;
      err_code_s = RT_FIFO_BYPASS_NONEMPTY;
    end else begin
      err_det_s  = 1'b0;
      err_code_s = 16'd0;
    end
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= ZERO_PTR;
      wr_ptr_r    <= ZERO_PTR;
      count_r     <= ZERO_CNT;
      err_valid_r <= 1'b0;
      err_code_r  <= 16'd0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
      if (!err_valid_r && err_det_s) begin
        err_valid_r <= 1'b1;
        err_code_r  <= err_code_s;
      end else begin
        err_valid_r <= err_valid_r;
        err_code_r  <= err_code_r;
      end
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= link.in_data;
    end
  end

  assign link.in_ready  = in_ready_s;
  assign link.out_valid = out_valid_s;
  assign link.out_data  = out_data_s;
  assign error_valid    = err_valid_r;
  assign error_code     = err_code_r;

endmodule

// File: tb/tb_fabric_fifo.sv
// Directed bench for fabric_fifo: three instances (DEPTH 4/3/2) cover fill/drain,
// wrap, random backpressure, bypass, error latching and mid-operation reset.
module tb_fabric_fifo;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fabric_fifo_if #(.PAYLOAD_WIDTH(8)) if4 ();
  fabric_fifo_if #(.PAYLOAD_WIDTH(8)) if3 ();
  fabric_fifo_if #(.PAYLOAD_WIDTH(8)) if2 ();

  logic        byp4, byp3, byp2;
  logic        ev4, ev3, ev2;
  logic [15:0] ec4, ec3, ec2;

  fabric_fifo #(.DEPTH(4), .DATA_WIDTH(8), .TAG_WIDTH(0), .BYPASSABLE(0)) u4 (
    .clk(clk), .rst_n(rst_n), .link(if4.slave), .cfg_bypass(byp4),
    .error_valid(ev4), .error_code(ec4));

  fabric_fifo #(.DEPTH(3), .DATA_WIDTH(8), .TAG_WIDTH(0), .BYPASSABLE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .link(if3.slave), .cfg_bypass(byp3),
    .error_valid(ev3), .error_code(ec3));

  fabric_fifo #(.DEPTH(2), .DATA_WIDTH(6), .TAG_WIDTH(2), .BYPASSABLE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .link(if2.slave), .cfg_bypass(byp2),
    .error_valid(ev2), .error_code(ec2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if4.out_valid); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if4.in_ready); end
    checks++; if (ev4 !== 1'b0) begin errors++; $display("FAIL reset_error_valid: got %b expected 0", ev4); end
    checks++; if (ec4 !== 16'd0) begin errors++; $display("FAIL reset_error_code: got %0d expected 0", ec4); end
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_d2: got %b expected 0", if2.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d [5];
    logic       acc;
    if4.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if4.in_valid = 1'b1;
      if4.in_data  = 8'hA0 + 8'(i);
      #1;
      checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, if4.in_ready); end
      tick();
    end
    if4.in_data = 8'hA4;
    #1;
    checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", if4.in_ready); end
    tick();
    checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_in_ready: got %b expected 0", if4.in_ready); end
    checks++; if (if4.out_data !== 8'hA0) begin errors++; $display("FAIL full_head: got %h expected a0", if4.out_data); end
    for (int k = 0; k < 5; k++) exp_d[k] = 8'hA0 + 8'(k);
    if4.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", k, if4.out_valid); end
      checks++; if (if4.out_data !== exp_d[k]) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", k, if4.out_data, exp_d[k]); end
      acc = if4.in_valid & if4.in_ready;
      tick();
      if (acc) if4.in_valid = 1'b0;
    end
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", if4.out_valid); end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    if3.out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if3.in_valid = (c < 10);
      if3.in_data  = 8'(c + 1);
      #1;
      checks++; if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_in_ready[%0d]: got %b expected 1", c, if3.in_ready); end
      if (c == 0) begin
        checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_first_latency: got %b expected 0", if3.out_valid); end
      end else begin
        checks++; if (if3.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected 1", c, if3.out_valid); end
        checks++; if (if3.out_data !== 8'(c)) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", c, if3.out_data, c); end
      end
      tick();
    end
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", if3.out_valid); end
    if3.in_valid  = 1'b0;
    if3.out_ready = 1'b0;
  endtask

  task automatic test_random_backpressure();
    logic [7:0] q [$];
    logic       push, pop, rdy_m, vld_m;
    for (int c = 0; c < 1000; c++) begin
      if2.in_valid  = 1'($urandom_range(0, 1));
      if2.out_ready = 1'($urandom_range(0, 1));
      if2.in_data   = 8'($urandom);
      #1;
      rdy_m = (q.size() != 2);
      vld_m = (q.size() != 0);
      checks++; if (if2.in_ready !== rdy_m) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, if2.in_ready, rdy_m); end
      checks++; if (if2.out_valid !== vld_m) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, if2.out_valid, vld_m); end
      if (vld_m) begin
        checks++; if (if2.out_data !== q[0]) begin errors++; $display("FAIL rand_out_data[%0d]: got %h expected %h", c, if2.out_data, q[0]); end
      end
      push = if2.in_valid & rdy_m;
      pop  = vld_m & if2.out_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(if2.in_data);
      tick();
    end
    if2.in_valid  = 1'b0;
    if2.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drained: got %b expected 0", if2.out_valid); end
    if2.out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    byp3          = 1'b1;
    if3.in_valid  = 1'b1;
    if3.in_data   = 8'h55;
    if3.out_ready = 1'b0;
    #1;
    checks++; if (if3.out_valid !== 1'b1) begin errors++; $display("FAIL byp_out_valid: got %b expected 1", if3.out_valid); end
    checks++; if (if3.out_data !== 8'h55) begin errors++; $display("FAIL byp_out_data: got %h expected 55", if3.out_data); end
    checks++; if (if3.in_ready !== 1'b0) begin errors++; $display("FAIL byp_ready_low: got %b expected 0", if3.in_ready); end
    if3.out_ready = 1'b1;
    #1;
    checks++; if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL byp_ready_high: got %b expected 1", if3.in_ready); end
    tick();
    tick();
    if3.in_valid = 1'b0;
    #1;
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL byp_valid_follow: got %b expected 0", if3.out_valid); end
    checks++; if (ev3 !== 1'b0) begin errors++; $display("FAIL byp_no_error: got %b expected 0", ev3); end
    byp3          = 1'b0;
    if3.out_ready = 1'b0;
    tick();
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL byp_nothing_stored: got %b expected 0", if3.out_valid); end
  endtask

  task automatic test_bypass_errors();
    // Bypass requested on an instance without bypass hardware
    byp4          = 1'b1;
    if4.in_valid  = 1'b1;
    if4.in_data   = 8'h77;
    if4.out_ready = 1'b0;
    #1;
    checks++; if (ev4 !== 1'b0) begin errors++; $display("FAIL err3_not_yet: got %b expected 0", ev4); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL err3_buffered_ready: got %b expected 1", if4.in_ready); end
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL err3_no_passthru: got %b expected 0", if4.out_valid); end
    tick();
    if4.in_valid = 1'b0;
    #1;
    checks++; if (ev4 !== 1'b1) begin errors++; $display("FAIL err3_valid: got %b expected 1", ev4); end
    checks++; if (ec4 !== 16'd3) begin errors++; $display("FAIL err3_code: got %0d expected 3", ec4); end
    checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 8'h77) begin errors++; $display("FAIL err3_buffered_data: got %b/%h expected 1/77", if4.out_valid, if4.out_data); end
    byp4          = 1'b0;
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
    checks++; if (ec4 !== 16'd3) begin errors++; $display("FAIL err3_sticky: got %0d expected 3", ec4); end

    // Bypass enabled with one entry stranded in the buffer
    if3.in_valid = 1'b1;
    if3.in_data  = 8'h11;
    tick();
    if3.in_valid = 1'b0;
    byp3         = 1'b1;
    #1;
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL err263_bypass_active: got %b expected 0", if3.out_valid); end
    checks++; if (ev3 !== 1'b0) begin errors++; $display("FAIL err263_not_yet: got %b expected 0", ev3); end
    tick();
    checks++; if (ev3 !== 1'b1) begin errors++; $display("FAIL err263_valid: got %b expected 1", ev3); end
    checks++; if (ec3 !== 16'd263) begin errors++; $display("FAIL err263_code: got %0d expected 263", ec3); end
    tick();
    tick();
    checks++; if (ec3 !== 16'd263) begin errors++; $display("FAIL err263_sticky: got %0d expected 263", ec3); end
    byp3 = 1'b0;
    #1;
    checks++; if (if3.out_valid !== 1'b1 || if3.out_data !== 8'h11) begin errors++; $display("FAIL err263_stranded: got %b/%h expected 1/11", if3.out_valid, if3.out_data); end
  endtask

  task automatic test_reset_mid_op();
    if4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if4.in_valid = 1'b1;
      if4.in_data  = 8'hB0 + 8'(i);
      tick();
    end
    if4.in_valid = 1'b0;
    #2;
    checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 8'hB0) begin errors++; $display("FAIL rst_pre_head: got %b/%h expected 1/b0", if4.out_valid, if4.out_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", if4.out_valid); end
    checks++; if (ev4 !== 1'b0) begin errors++; $display("FAIL rst_async_err4: got %b expected 0", ev4); end
    checks++; if (ec4 !== 16'd0) begin errors++; $display("FAIL rst_async_code4: got %0d expected 0", ec4); end
    checks++; if (ev3 !== 1'b0 || if3.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_d3: got %b/%b expected 0/0", ev3, if3.out_valid); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", if4.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    if4.in_valid = 1'b1;
    if4.in_data  = 8'hC0;
    tick();
    if4.in_data  = 8'hC1;
    tick();
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    #1;
    checks++; if (if4.out_data !== 8'hC0) begin errors++; $display("FAIL rst_first_pop: got %h expected c0", if4.out_data); end
    tick();
    checks++; if (if4.out_data !== 8'hC1) begin errors++; $display("FAIL rst_second_pop: got %h expected c1", if4.out_data); end
    tick();
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_empty: got %b expected 0", if4.out_valid); end
    if4.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    byp4 = 1'b0; byp3 = 1'b0; byp2 = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = 8'h00; if4.out_ready = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = 8'h00; if3.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = 8'h00; if2.out_ready = 1'b0;
    #12;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_random_backpressure();
    test_bypass();
    test_bypass_errors();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_fifo.md
# fabric_fifo

Elastic buffer stage for one streaming fabric channel, placed directly downstream of a switch output or any other stream producer. It breaks combinational valid/ready/data chains by registering data into a circular buffer of DEPTH entries. A configuration bit can optionally turn it into a combinational pass-through. Misconfiguration is reported through the same sticky error-latch scheme used by the other fabric blocks.

## Interface
- DEPTH, default 2: number of storage entries; must be ≥1 and ≤256; non-power-of-two allowed.
- DATA_WIDTH, default 32: payload data bits.
- TAG_WIDTH, default 0: tag bits carried alongside data; PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH.
- BYPASSABLE, default 0: 1 = cfg_bypass honoured; 0 = bypass hardware absent.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  FIFO can accept this cycle.
- in_data  in  PAYLOAD_WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  PAYLOAD_WIDTH  head payload.
- cfg_bypass  in  1  static configuration; 1 = pass-through.
- error_valid  out  1  sticky error flag.
- error_code  out  16  code of first latched error.

## Operation
- Elaboration: DEPTH<1 or DEPTH>256 triggers $fatal "COMP_FIFO_DEPTH".
- State:
  - storage array [DEPTH][PAYLOAD_WIDTH];
  - rd_ptr, wr_ptr each $clog2(DEPTH) bits (minimum 1);
  - count, $clog2(DEPTH+1) bits.
- Buffered mode (cfg_bypass=0, or BYPASSABLE=0):
  - in_ready = (count != DEPTH); it does not depend on out_ready, so there is no combinational ready path.
  - out_valid = (count != 0); out_data = storage[rd_ptr]. Contents of out_data when count==0 are don't-care.
  - Push = in_valid & in_ready: write storage[wr_ptr], then advance wr_ptr.
  - Pop = out_valid & out_ready: advance rd_ptr.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not by power-of-two masking.
  - count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
  - Simultaneous push and pop while full: push is refused because in_ready=0; the pop proceeds.
  - Simultaneous push and pop while empty: push only, because out_valid=0.
- Bypass mode (BYPASSABLE=1 and cfg_bypass=1):
  - out_valid = in_valid, out_data = in_data, in_ready = out_ready, all combinational.
  - Storage and pointers hold their values; no push or pop occurs.
- Error detection is combinational. When several errors are detected in the same cycle, the lowest code wins.
  - Code 3, CFG_FIFO_BYPASS_UNSUPPORTED: cfg_bypass=1 while BYPASSABLE=0. The block stays in buffered mode.
  - Code 263, RT_FIFO_BYPASS_NONEMPTY: cfg_bypass=1, BYPASSABLE=1 and count!=0. Bypass mode still takes effect; stranded entries remain until reset.
- Error latch:
  - When error_valid=0 and an error is detected, the latch captures error_valid=1 and the code on the next edge.
  - Once set, the latch holds until reset. Later errors are ignored.

## Timing
- Reset (asynchronous assert, release synchronised by the environment):
  - count=0, rd_ptr=0, wr_ptr=0;
  - out_valid=0, error_valid=0, error_code=0;
  - in_ready=1 in buffered mode.
  - Storage contents are not reset.
- Reset asserted mid-transfer drops all buffered entries immediately. No partial pop is visible.
- Buffered latency: a word accepted at edge N appears with out_valid=1 in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained when DEPTH≥2. With DEPTH=1, throughput is 1 word every 2 cycles under continuous flow, because in_ready ignores out_ready.
- Bypass latency is 0 cycles.
- Handshake: out_valid and out_data stay stable until out_ready is sampled high.
- Error: error_valid rises 1 cycle after the detecting condition.

## Test plan
- Fill/drain, DEPTH=4, out_ready=0: push 0xA0..0xA3.
  - in_ready goes low after the 4th accept; a 5th word 0xA4 is held off.
  - Raise out_ready: outputs 0xA0, 0xA1, 0xA2, 0xA3 in order on consecutive cycles, then 0xA4.
- Wrap, DEPTH=3: stream 10 words 1..10 with out_ready=1 continuously.
  - Output sequence is 1..10 with no gaps after the first-word latency of 1 cycle.
  - Pointers wrap 2→0 three times.
- Random backpressure, DEPTH=2: random in_valid/out_ready for 1000 cycles.
  - Output order matches a scoreboard.
  - count never exceeds 2; no loss or duplication.
- Bypass, BYPASSABLE=1, FIFO empty, cfg_bypass=1, in_data=0x55, in_valid=1:
  - out_data=0x55 and out_valid=1 in the same cycle; in_ready follows out_ready.
  - error_valid stays 0.
- Bypass errors:
  - BYPASSABLE=0, cfg_bypass=1: next cycle error_valid=1, error_code=3; data still buffered.
  - BYPASSABLE=1, 1 entry stored, cfg_bypass=1: error_code=263, which stays latched despite later errors.
- Reset mid-operation: assert rst_n=0 with 3 words stored.
  - out_valid=0 and error_valid=0 asynchronously.
  - After release, the first pushed word is the first popped.
